axis_sample_scaler: RTL and testbench

//  Streaming datapath stage directly downstream of the scaling_interface AXI4-Lite register slave.

---
 rtl/axis_sample_scaler_if.sv | 13 +
 rtl/axis_sample_scaler.sv | 192 +++++++++++++++++++
 tb/tb_axis_sample_scaler.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_sample_scaler_if.sv
// AXI-Stream sample channel shared by the scaler's input and output sides.
// The master drives data/valid/last, the slave answers with ready.
interface axis_sample_scaler_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_sample_scaler.sv
// Three-stage streaming scaler: y = sat(round((x*gain) >>> shift) + offset).
// Configuration is latched per frame and travels down the pipeline with each beat.
module axis_sample_scaler #(
    parameter int DATA_WIDTH = 16,
    parameter int GAIN_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [31:0]               cfg_gain,
    input  logic [31:0]               cfg_shift,
    input  logic [31:0]               cfg_offset,
    input  logic [31:0]               cfg_ctrl,
    axis_sample_scaler_if.slave       s_axis,
    axis_sample_scaler_if.master      m_axis,
    output logic [CNT_WIDTH-1:0]      sat_count,
    output logic                      frame_active
);
    localparam int PW = DATA_WIDTH + GAIN_WIDTH;
    localparam int W2 = PW + 2;
    localparam logic signed [W2-1:0] SAT_MAX = {{(W2-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [W2-1:0] SAT_MIN = {{(W2-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic {IDLE, IN_FRAME} state_t;

    state_t state_q, state_d;

    logic signed [GAIN_WIDTH-1:0] sh_gain, eff_gain;
    logic [4:0]                   sh_shift, eff_shift;
    logic signed [DATA_WIDTH-1:0] sh_offset, eff_offset;
    logic                         sh_bypass, eff_bypass;

    logic                         s1_valid, s1_bypass, s1_last;
    logic signed [PW-1:0]         s1_prod;
    logic [DATA_WIDTH-1:0]        s1_x;
    logic [4:0]                   s1_shift;
    logic signed [DATA_WIDTH-1:0] s1_offset;

    logic                         s2_valid, s2_bypass, s2_last;
    logic signed [W2-1:0]         s2_r;
    logic [DATA_WIDTH-1:0]        s2_x;

    logic                         m_valid_q, m_last_q, m_sat_q;
    logic [DATA_WIDTH-1:0]        m_data_q;

    logic                         accept, s1_load, s2_load, s3_load;
    logic signed [DATA_WIDTH-1:0] x_s;
    logic signed [W2-1:0]         p_ext, half, off_ext, r_next;
    logic [DATA_WIDTH-1:0]        y_next;
    logic                         sat_next;
    logic                         unused_cfg_bits;

    assign unused_cfg_bits = ^{cfg_gain[31:GAIN_WIDTH], cfg_shift[31:5],
                               cfg_offset[31:DATA_WIDTH], cfg_ctrl[31:3]};

    // A stage may load when it is empty or its contents move on this cycle.
    assign s3_load       = !m_valid_q || m_axis.tready;
    assign s2_load       = !s2_valid || s3_load;
    assign s1_load       = !s1_valid || s2_load;
    assign s_axis.tready = cfg_ctrl[0] && s1_load;
    assign accept        = s_axis.tvalid && s_axis.tready;
    assign x_s           = s_axis.tdata;

    assign m_axis.tdata  = m_data_q;
    assign m_axis.tvalid = m_valid_q;
    assign m_axis.tlast  = m_last_q;
    assign frame_active  = (state_q == IN_FRAME);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            sh_gain   <= '0;
            sh_shift  <= '0;
            sh_offset <= '0;
            sh_bypass <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept && state_q == IDLE) begin
                sh_gain   <= cfg_gain[GAIN_WIDTH-1:0];
                sh_shift  <= cfg_shift[4:0];
                sh_offset <= cfg_offset[DATA_WIDTH-1:0];
                sh_bypass <= cfg_ctrl[1];
            end
        end
    end

    // Outside a frame the live registers apply; inside, the frozen copy does.
    always_comb begin
        state_d    = state_q;
        eff_gain   = cfg_gain[GAIN_WIDTH-1:0];
        eff_shift  = cfg_shift[4:0];
        eff_offset = cfg_offset[DATA_WIDTH-1:0];
        eff_bypass = cfg_ctrl[1];
        case (state_q)
            IDLE: begin
                if (accept && !s_axis.tlast) state_d = IN_FRAME;
            end
            IN_FRAME: begin
                eff_gain   = sh_gain;
                eff_shift  = sh_shift;
                eff_offset = sh_offset;
                eff_bypass = sh_bypass;
                if (accept && s_axis.tlast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1_valid  <= 1'b0;
            s1_prod   <= '0;
            s1_x      <= '0;
            s1_shift  <= '0;
            s1_offset <= '0;
            s1_bypass <= 1'b0;
            s1_last   <= 1'b0;
        end else if (s1_load) begin
            s1_valid  <= accept;
            s1_prod   <= PW'(x_s) * PW'(eff_gain);
            s1_x      <= s_axis.tdata;
            s1_shift  <= eff_shift;
            s1_offset <= eff_offset;
            s1_bypass <= eff_bypass;
            s1_last   <= s_axis.tlast;
        end
    end

    // Adding half an LSB before the arithmetic shift rounds ties upward.
    always_comb begin
        p_ext   = W2'(s1_prod);
        off_ext = W2'(s1_offset);
        half    = '0;
        if (s1_shift != 5'd0) half = W2'(1) << (s1_shift - 5'd1);
        r_next  = ((p_ext + half) >>> s1_shift) + off_ext;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s2_valid  <= 1'b0;
            s2_r      <= '0;
            s2_x      <= '0;
            s2_bypass <= 1'b0;
            s2_last   <= 1'b0;
        end else if (s2_load) begin
            s2_valid  <= s1_valid;
            s2_r      <= r_next;
            s2_x      <= s1_x;
            s2_bypass <= s1_bypass;
            s2_last   <= s1_last;
        end
    end

    always_comb begin
        y_next   = s2_r[DATA_WIDTH-1:0];
        sat_next = 1'b0;
        if (s2_bypass) begin
            y_next = s2_x;
        end else if (s2_r > SAT_MAX) begin
            y_next   = SAT_MAX[DATA_WIDTH-1:0];
            sat_next = 1'b1;
        end else if (s2_r < SAT_MIN) begin
            y_next   = SAT_MIN[DATA_WIDTH-1:0];
            sat_next = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            m_sat_q   <= 1'b0;
        end else if (s3_load) begin
            m_valid_q <= s2_valid;
            m_data_q  <= y_next;
            m_last_q  <= s2_last;
            m_sat_q   <= sat_next;
        end
    end

    // Clear has priority; the counter sticks once it reaches all-ones.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sat_count <= '0;
        end else if (cfg_ctrl[2]) begin
            sat_count <= '0;
        end else if (m_valid_q && m_axis.tready && m_sat_q && sat_count != '1) begin
            sat_count <= sat_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_axis_sample_scaler.sv
// Randomised and directed bench for axis_sample_scaler against a per-frame arithmetic reference model.
// One call to applyStimulus is one clock cycle; expectations are queued on accept and matched on output.
module tb_axis_sample_scaler;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [31:0] cfg_gain = '0, cfg_shift = '0, cfg_offset = '0, cfg_ctrl = '0;
    logic [31:0] gain_n = '0, shift_n = '0, offset_n = '0, ctrl_n = '0;
    logic [15:0] sat_count;
    logic        frame_active;

    axis_sample_scaler_if #(.DATA_WIDTH(16)) s_if ();
    axis_sample_scaler_if #(.DATA_WIDTH(16)) m_if ();

    axis_sample_scaler #(.DATA_WIDTH(16), .GAIN_WIDTH(16), .CNT_WIDTH(16)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .cfg_gain     (cfg_gain),
        .cfg_shift    (cfg_shift),
        .cfg_offset   (cfg_offset),
        .cfg_ctrl     (cfg_ctrl),
        .s_axis       (s_if),
        .m_axis       (m_if),
        .sat_count    (sat_count),
        .frame_active (frame_active)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [15:0] data;
        logic        last;
        logic        sat;
    } beat_t;

    beat_t       exp_q[$];
    logic [15:0] out_log[$];
    int          last_count = 0;
    int          checks = 0;
    int          errors = 0;
    logic        in_frame_m = 1'b0;
    logic [31:0] sh_gain = '0, sh_shift = '0, sh_offset = '0, sh_ctrl = '0;
    logic [15:0] sat_m = '0;
    logic        hold_pending = 1'b0;
    logic [16:0] held = '0;
    logic        accepted = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    function automatic beat_t refBeat(input logic [15:0] x, input logic last,
                                      input logic [31:0] g, input logic [31:0] sh,
                                      input logic [31:0] off, input logic [31:0] ctrl);
        beat_t  b;
        longint p, r;
        int     s;
        b.last = last;
        b.sat  = 1'b0;
        b.data = x;
        if (!ctrl[1]) begin
            p = longint'($signed(x)) * longint'($signed(g[15:0]));
            s = int'(sh[4:0]);
            r = (s == 0) ? p : ((p + (longint'(1) <<< (s - 1))) >>> s);
            r = r + longint'($signed(off[15:0]));
            if (r > 32767) begin
                b.data = 16'h7FFF;
                b.sat  = 1'b1;
            end else if (r < -32768) begin
                b.data = 16'h8000;
                b.sat  = 1'b1;
            end else begin
                b.data = r[15:0];
            end
        end
        return b;
    endfunction

    task automatic applyStimulus(input logic vld, input logic [15:0] data, input logic last, input logic rdy);
        beat_t e;
        @(negedge clk_in);
        cfg_gain = gain_n; cfg_shift = shift_n; cfg_offset = offset_n; cfg_ctrl = ctrl_n;
        s_if.tvalid = vld; s_if.tdata = data; s_if.tlast = last; m_if.tready = rdy;
        #1;
        checkOutput("sat_count", 32'(sat_count), 32'(sat_m));
        checkOutput("frame_active", 32'(frame_active), 32'(in_frame_m));
        if (!cfg_ctrl[0]) checkOutput("tready_gated", 32'(s_if.tready), 32'd0);
        if (hold_pending)
            checkOutput("hold_stable", {14'd0, m_if.tvalid, m_if.tlast, m_if.tdata}, {14'd0, 1'b1, held});
        hold_pending = m_if.tvalid && !m_if.tready;
        held = {m_if.tlast, m_if.tdata};
        if (m_if.tvalid && m_if.tready) begin
            checkOutput("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checkOutput("out_data", 32'(m_if.tdata), 32'(e.data));
                checkOutput("out_last", 32'(m_if.tlast), 32'(e.last));
                out_log.push_back(m_if.tdata);
                if (m_if.tlast) last_count++;
                if (e.sat && sat_m != 16'hFFFF) sat_m++;
            end
        end
        if (cfg_ctrl[2]) sat_m = '0;
        accepted = s_if.tvalid && s_if.tready;
        if (accepted) begin
            if (in_frame_m) begin
                e = refBeat(data, last, sh_gain, sh_shift, sh_offset, sh_ctrl);
                if (last) in_frame_m = 1'b0;
            end else begin
                e = refBeat(data, last, cfg_gain, cfg_shift, cfg_offset, cfg_ctrl);
                sh_gain = cfg_gain; sh_shift = cfg_shift; sh_offset = cfg_offset; sh_ctrl = cfg_ctrl;
                if (!last) in_frame_m = 1'b1;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic resetDut();
        @(negedge clk_in);
        rst_in = 1'b1;
        s_if.tvalid = 1'b0; m_if.tready = 1'b0;
        cfg_gain = gain_n; cfg_shift = shift_n; cfg_offset = offset_n; cfg_ctrl = ctrl_n;
        @(negedge clk_in);
        #1;
        checkOutput("rst_tvalid", 32'(m_if.tvalid), 32'd0);
        checkOutput("rst_tdata", 32'(m_if.tdata), 32'd0);
        checkOutput("rst_tlast", 32'(m_if.tlast), 32'd0);
        checkOutput("rst_sat_count", 32'(sat_count), 32'd0);
        checkOutput("rst_frame_active", 32'(frame_active), 32'd0);
        rst_in = 1'b0;
        exp_q.delete();
        out_log.delete();
        last_count = 0;
        in_frame_m = 1'b0;
        sh_gain = '0; sh_shift = '0; sh_offset = '0; sh_ctrl = '0;
        sat_m = '0;
        hold_pending = 1'b0;
    endtask

    task automatic drainPipe();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) applyStimulus(1'b0, 16'd0, 1'b0, 1'b1);
        checkOutput("drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic setCfg(input logic [31:0] g, input logic [31:0] sh, input logic [31:0] off, input logic [31:0] ctrl);
        gain_n = g; shift_n = sh; offset_n = off; ctrl_n = ctrl;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int idx;
        logic [3:0] pat;
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; m_if.tready = 1'b0;

        // Unity gain via 256 >> 8, with latency measured on the first beat.
        setCfg(32'h100, 32'd8, 32'd0, 32'd1);
        resetDut();
        applyStimulus(1'b1, 16'd1000, 1'b0, 1'b1);
        lat = 0;
        for (int n = 0; n < 10 && out_log.size() == 0; n++) begin
            applyStimulus(1'b0, 16'd0, 1'b0, 1'b1);
            lat++;
        end
        checkOutput("t1_latency", 32'(lat), 32'd3);
        applyStimulus(1'b1, 16'(-1000), 1'b0, 1'b1);
        applyStimulus(1'b1, 16'd0, 1'b1, 1'b1);
        drainPipe();
        checkOutput("t1_out0", 32'(out_log[0]), 32'd1000);
        checkOutput("t1_out1", 32'(out_log[1]), 32'h0000FC18);
        checkOutput("t1_out2", 32'(out_log[2]), 32'd0);

        // Saturation both ways, then clear.
        setCfg(32'h7FFF, 32'd0, 32'd0, 32'd1);
        resetDut();
        applyStimulus(1'b1, 16'h4000, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'hC000, 1'b1, 1'b1);
        drainPipe();
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b1);
        checkOutput("t2_out0", 32'(out_log[0]), 32'h7FFF);
        checkOutput("t2_out1", 32'(out_log[1]), 32'h8000);
        checkOutput("t2_sat_count", 32'(sat_count), 32'd2);
        ctrl_n = 32'd5;
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b1);
        ctrl_n = 32'd1;
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b1);
        checkOutput("t2_sat_cleared", 32'(sat_count), 32'd0);

        // Round-half-up ties and a negative offset.
        setCfg(32'd1, 32'd1, 32'd0, 32'd1);
        resetDut();
        applyStimulus(1'b1, 16'(-3), 1'b0, 1'b1);
        applyStimulus(1'b1, 16'd3, 1'b1, 1'b1);
        drainPipe();
        setCfg(32'd256, 32'd8, 32'(-200), 32'd1);
        applyStimulus(1'b1, 16'd100, 1'b1, 1'b1);
        drainPipe();
        checkOutput("t3_out0", 32'(out_log[0]), 32'hFFFF);
        checkOutput("t3_out1", 32'(out_log[1]), 32'd2);
        checkOutput("t3_out2", 32'(out_log[2]), 32'hFF9C);

        // Gain change mid-frame must not affect the frame in flight.
        setCfg(32'd256, 32'd8, 32'd0, 32'd1);
        resetDut();
        applyStimulus(1'b1, 16'd10, 1'b0, 1'b1);
        gain_n = 32'd512;
        applyStimulus(1'b1, 16'd20, 1'b0, 1'b1);
        checkOutput("t4_frame_active", 32'(frame_active), 32'd1);
        applyStimulus(1'b1, 16'd30, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'd40, 1'b1, 1'b1);
        applyStimulus(1'b1, 16'd10, 1'b1, 1'b1);
        drainPipe();
        checkOutput("t4_out0", 32'(out_log[0]), 32'd10);
        checkOutput("t4_out3", 32'(out_log[3]), 32'd40);
        checkOutput("t4_out4", 32'(out_log[4]), 32'd20);

        // Ramp under a 1,0,0,1 ready pattern.
        setCfg(32'd256, 32'd8, 32'd0, 32'd1);
        resetDut();
        pat = 4'b1001;
        idx = 0;
        for (int n = 0; n < 200 && (idx < 16 || exp_q.size() != 0); n++) begin
            applyStimulus(idx < 16, 16'(idx), idx == 15, pat[n % 4]);
            if (accepted) idx++;
        end
        checkOutput("t5_count", 32'(out_log.size()), 32'd16);
        for (int k = 0; k < 16; k++) checkOutput("t5_order", 32'(out_log[k]), 32'(k));
        checkOutput("t5_last_count", 32'(last_count), 32'd1);

        // Enable low blocks input.
        ctrl_n = 32'd0;
        applyStimulus(1'b1, 16'd7, 1'b1, 1'b1);
        ctrl_n = 32'd1;
        drainPipe();

        // Reset with three beats stuck in the pipeline.
        setCfg(32'd256, 32'd8, 32'd0, 32'd1);
        resetDut();
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 16'(k + 5), 1'b0, 1'b0);
        resetDut();
        for (int k = 0; k < 8; k++) applyStimulus(1'b0, 16'd0, 1'b0, 1'b1);
        checkOutput("t6_no_output", 32'(out_log.size()), 32'd0);

        // Randomised traffic with live configuration churn.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                gain_n   = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 1023));
                shift_n  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 16));
                offset_n = $urandom;
                ctrl_n   = {29'($urandom), $urandom_range(0, 29) == 0,
                            $urandom_range(0, 4) == 0, $urandom_range(0, 9) != 0};
            end
            applyStimulus($urandom_range(0, 3) != 0, 16'($urandom),
                          $urandom_range(0, 5) == 0, $urandom_range(0, 9) < 7);
        end
        ctrl_n = 32'd1;
        drainPipe();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
